// File: rtl/adder4_sum_accumulator_pkg.sv
// Shared definitions for the adder4 result accumulator: sample width and FSM state encodings.
package adder4_pkg;

    localparam int SAMPLE_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder4_sum_accumulator_if.sv
// Control, sample-input and result-output signals of the adder4 result accumulator.
interface adder4_sum_accumulator_if #(
    parameter int ACC_W       = 12,
    parameter int NUM_SAMPLES = 8
);
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    logic             start;
    logic             clr;
    logic             in_valid;
    logic [3:0]       Sum;
    logic             Carry;
    logic             in_ready;
    logic [ACC_W-1:0] Acc;
    logic             Overflow;
    logic [CNT_W-1:0] Count;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, clr, in_valid, Sum, Carry, out_ready,
        input  in_ready, Acc, Overflow, Count, out_valid, busy
    );

    modport slave (
        input  start, clr, in_valid, Sum, Carry, out_ready,
        output in_ready, Acc, Overflow, Count, out_valid, busy
    );
endinterface

// File: rtl/adder4_sum_accumulator.sv
// Accumulates NUM_SAMPLES {Carry,Sum} adder results into an ACC_W-bit total with a sticky
// overflow flag, presented on a valid/ready output port.
module adder4_sum_accumulator
    import adder4_pkg::*;
#(
    parameter int ACC_W       = 12,
    parameter int NUM_SAMPLES = 8,
    parameter bit SATURATE    = 1'b0
) (
    input logic                      clk,
    input logic                      rst,
    adder4_sum_accumulator_if.slave  bus
);
    localparam int               CNT_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES);

    state_t            r_state, w_state_next;
    logic [ACC_W-1:0]  r_acc, w_acc_next;
    logic              r_ovf, w_ovf_next;
    logic [CNT_W-1:0]  r_count, w_count_next;
    logic [SAMPLE_W-1:0] w_sample;
    logic [ACC_W:0]    w_sum;
    logic              w_accept;

    assign w_sample = {bus.Carry, bus.Sum};
    assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(w_sample);
    assign w_accept = bus.in_valid && (r_state == ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_ovf   <= w_ovf_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_ovf_next   = r_ovf;
        w_count_next = r_count;
        // clr outranks start and any sample presented in the same cycle
        if (bus.clr) begin
            w_state_next = IDLE;
            w_acc_next   = '0;
            w_ovf_next   = 1'b0;
            w_count_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_state_next = ACCUM;
                        w_acc_next   = '0;
                        w_ovf_next   = 1'b0;
                        w_count_next = '0;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        w_count_next = r_count + 1'b1;
                        if (w_sum[ACC_W]) begin
                            w_ovf_next = 1'b1;
                            w_acc_next = SATURATE ? '1 : w_sum[ACC_W-1:0];
                        end else begin
                            w_acc_next = w_sum[ACC_W-1:0];
                        end
                        if (r_count + 1'b1 == LAST_CNT)
                            w_state_next = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ACCUM);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == ACCUM) || (r_state == DONE);
    assign bus.Acc       = r_acc;
    assign bus.Overflow  = r_ovf;
    assign bus.Count     = r_count;

endmodule

// File: tb/tb_adder4_sum_accumulator.sv
// Directed bench for adder4_sum_accumulator: three parameterisations, scoreboard of run totals.
module tb_adder4_sum_accumulator;

    localparam int A_W = 12, A_N = 4;
    localparam int B_W = 5,  B_N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder4_sum_accumulator_if #(.ACC_W(A_W), .NUM_SAMPLES(A_N)) ifa ();
    adder4_sum_accumulator_if #(.ACC_W(B_W), .NUM_SAMPLES(B_N)) ifb ();
    adder4_sum_accumulator_if #(.ACC_W(B_W), .NUM_SAMPLES(B_N)) ifc ();

    adder4_sum_accumulator #(.ACC_W(A_W), .NUM_SAMPLES(A_N), .SATURATE(1'b0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    adder4_sum_accumulator #(.ACC_W(B_W), .NUM_SAMPLES(B_N), .SATURATE(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    adder4_sum_accumulator #(.ACC_W(B_W), .NUM_SAMPLES(B_N), .SATURATE(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct {
        int acc;
        int ovf;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_acc, m_ovf, m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-18s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_add(input int acc, input int smp, input int w,
                                     input bit sat, output bit ovf);
        int s;
        s   = acc + smp;
        ovf = (s >> w) != 0;
        if (ovf) return sat ? ((1 << w) - 1) : (s & ((1 << w) - 1));
        return s;
    endfunction

    task automatic a_start();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        m_acc = 0; m_ovf = 0; m_cnt = 0;
        check("start_in_ready", ifa.in_ready, 1);
        check("start_acc", ifa.Acc, 0);
        check("start_count", ifa.Count, 0);
    endtask

    task automatic a_send(input int val);
        bit ovf;
        ifa.Sum      = 4'(val);
        ifa.Carry    = val[4];
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        m_acc = model_add(m_acc, val, A_W, 1'b0, ovf);
        if (ovf) m_ovf = 1;
        m_cnt++;
        if (m_cnt == A_N) sb_q.push_back('{acc: m_acc, ovf: m_ovf, cnt: m_cnt});
        check("send_acc", ifa.Acc, m_acc);
        check("send_count", ifa.Count, m_cnt);
        check("send_out_valid", ifa.out_valid, (m_cnt == A_N) ? 1 : 0);
    endtask

    task automatic a_collect();
        exp_t e;
        int   waited;
        waited = 0;
        while (ifa.out_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("collect_out_valid", ifa.out_valid, 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_acc", ifa.Acc, e.acc);
            check("sb_overflow", ifa.Overflow, e.ovf);
            check("sb_count", ifa.Count, e.cnt);
            // start alongside out_ready must not launch a new run
            ifa.out_ready = 1'b1;
            ifa.start     = 1'b1;
            tick();
            ifa.out_ready = 1'b0;
            ifa.start     = 1'b0;
            check("rel_out_valid", ifa.out_valid, 0);
            check("rel_busy", ifa.busy, 0);
            check("rel_in_ready", ifa.in_ready, 0);
            check("idle_acc_held", ifa.Acc, e.acc);
        end
    endtask

    initial begin
        ifa.start = 0; ifa.clr = 0; ifa.in_valid = 0; ifa.Sum = 0; ifa.Carry = 0; ifa.out_ready = 0;
        ifb.start = 0; ifb.clr = 0; ifb.in_valid = 0; ifb.Sum = 0; ifb.Carry = 0; ifb.out_ready = 0;
        ifc.start = 0; ifc.clr = 0; ifc.in_valid = 0; ifc.Sum = 0; ifc.Carry = 0; ifc.out_ready = 0;
        #1;
        check("rst_acc", ifa.Acc, 0);
        check("rst_count", ifa.Count, 0);
        check("rst_overflow", ifa.Overflow, 0);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_in_ready", ifa.in_ready, 0);
        check("rst_busy", ifa.busy, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // basic run: 14, 5, 26, 16 -> 61
        a_start();
        a_send(14); a_send(5); a_send(26); a_send(16);
        check("t1_acc_61", ifa.Acc, 12'h03D);
        check("t1_overflow", ifa.Overflow, 0);

        // backpressure in DONE with noise on in_valid/start
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = i[0] ? 1'b0 : 1'b1;
            ifa.start    = i[0] ? 1'b1 : 1'b0;
            ifa.Sum      = 4'd7;
            tick();
            check("bp_acc", ifa.Acc, 61);
            check("bp_count", ifa.Count, 4);
            check("bp_in_ready", ifa.in_ready, 0);
            check("bp_out_valid", ifa.out_valid, 1);
        end
        ifa.in_valid = 1'b0;
        ifa.start    = 1'b0;
        a_collect();
        tick();
        check("idle_stays_idle", ifa.busy, 0);

        // gaps in in_valid
        a_start();
        a_send(5); tick(); tick();
        check("gap_count", ifa.Count, 1);
        a_send(5); a_send(5); a_send(5);
        check("gap_acc_20", ifa.Acc, 20);
        a_collect();

        // narrow accumulators: wrap vs saturate
        ifb.start = 1'b1; ifc.start = 1'b1;
        tick();
        ifb.start = 1'b0; ifc.start = 1'b0;
        ifb.Sum = 4'd10; ifb.Carry = 1'b1; ifb.in_valid = 1'b1;
        ifc.Sum = 4'd10; ifc.Carry = 1'b1; ifc.in_valid = 1'b1;
        tick();
        check("b_acc_26", ifb.Acc, 26);
        check("b_ovf_first", ifb.Overflow, 0);
        ifb.Sum = 4'd0; ifb.Carry = 1'b1;
        ifc.Sum = 4'd0; ifc.Carry = 1'b1;
        tick();
        ifb.in_valid = 1'b0; ifc.in_valid = 1'b0;
        check("b_wrap_acc", ifb.Acc, 10);
        check("b_wrap_ovf", ifb.Overflow, 1);
        check("b_out_valid", ifb.out_valid, 1);
        check("c_sat_acc", ifc.Acc, 31);
        check("c_sat_ovf", ifc.Overflow, 1);
        check("c_out_valid", ifc.out_valid, 1);
        ifb.out_ready = 1'b1; ifc.out_ready = 1'b1;
        tick();
        ifb.out_ready = 1'b0; ifc.out_ready = 1'b0;
        check("bc_idle", {ifb.busy, ifc.busy}, 0);

        // asynchronous reset mid-run, observed before any clock edge
        a_start();
        a_send(14); a_send(5);
        rst = 1'b1;
        #1;
        check("arst_acc", ifa.Acc, 0);
        check("arst_count", ifa.Count, 0);
        check("arst_busy", ifa.busy, 0);
        check("arst_in_ready", ifa.in_ready, 0);
        check("arst_out_valid", ifa.out_valid, 0);
        check("arst_overflow", ifa.Overflow, 0);
        #1;
        rst = 1'b0;
        tick();

        // synchronous clear with a sample in the same cycle
        a_start();
        a_send(14); a_send(5);
        ifa.Sum = 4'd9; ifa.Carry = 1'b0; ifa.in_valid = 1'b1; ifa.clr = 1'b1;
        tick();
        ifa.in_valid = 1'b0; ifa.clr = 1'b0;
        check("clr_acc", ifa.Acc, 0);
        check("clr_count", ifa.Count, 0);
        check("clr_busy", ifa.busy, 0);
        check("clr_in_ready", ifa.in_ready, 0);

        // start during ACCUM is ignored
        a_start();
        a_send(14);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        check("ign_start_acc", ifa.Acc, 14);
        check("ign_start_count", ifa.Count, 1);
        a_send(5); a_send(26); a_send(16);
        a_collect();
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
